// File: rtl/pcpu_pkg.sv
// Shared definitions for the pcpu core: opcode values, controller states and
// the operation selector of the ALU.
package pcpu_pkg;

   localparam logic [3:0] OP_LDI  = 4'd0;
   localparam logic [3:0] OP_ST   = 4'd1;
   localparam logic [3:0] OP_LD   = 4'd2;
   localparam logic [3:0] OP_ADDI = 4'd3;
   localparam logic [3:0] OP_SUBI = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_ADD  = 4'd8;
   localparam logic [3:0] OP_SUB  = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MEM  = 2'd2,
      S_WB   = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      ALU_PASS = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_OR   = 3'd4,
      ALU_XOR  = 3'd5
   } alu_op_t;

endpackage

// File: rtl/pcpu_alu.sv
// Combinational ALU. carry is the adder carry-out for ADD and the borrow
// (a < b) for SUB; it is 0 for the logic operations and PASS.
module pcpu_alu
   import pcpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  alu_op_t           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);

   logic [DATA_W:0] wide_s;

   // One extra bit holds the carry or borrow of the arithmetic operations
   always_comb begin
      wide_s = {(DATA_W+1){1'b0}};
      case (op)
         ALU_PASS: wide_s = {1'b0, b};
         ALU_ADD:  wide_s = {1'b0, a} + {1'b0, b};
         ALU_SUB:  wide_s = {1'b0, a} - {1'b0, b};
         ALU_AND:  wide_s = {1'b0, a & b};
         ALU_OR:   wide_s = {1'b0, a | b};
         ALU_XOR:  wide_s = {1'b0, a ^ b};
         default:  wide_s = {(DATA_W+1){1'b0}};
      endcase
      result = wide_s[DATA_W-1:0];
      carry  = wide_s[DATA_W];
      zero   = (wide_s[DATA_W-1:0] == {DATA_W{1'b0}});
   end

endmodule

// File: rtl/pcpu_core.sv
// Small multi-cycle accumulator-style core: IDLE -> EXEC -> (MEM) -> WB with an
// inline register file and a single shared ALU.
module pcpu_core
   import pcpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NREGS  = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              flag_z,
   output logic              flag_c,
   output logic              illegal
);

   localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

   state_t            state_q, state_d;
   logic [15:0]       instr_q, instr_d;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [DATA_W-1:0] result_q, result_d;
   logic              flag_z_q, flag_z_d;
   logic              flag_c_q, flag_c_d;

   logic [3:0]        op_s;
   logic [RIDX_W-1:0] rd_s, rs_s;
   logic [DATA_W-1:0] imm_s, rd_val_s, rs_val_s;
   alu_op_t           alu_op_s;
   logic [DATA_W-1:0] alu_b_s, alu_res_s;
   logic              alu_carry_s, alu_zero_s;
   logic              illegal_s;

   // Field decode of the latched instruction and ALU operand selection
   always_comb begin
      op_s     = instr_q[15:12];
      rd_s     = instr_q[8 +: RIDX_W];
      rs_s     = instr_q[4 +: RIDX_W];
      imm_s    = DATA_W'(instr_q[7:0]);
      rd_val_s = regs_q[rd_s];
      rs_val_s = regs_q[rs_s];
      alu_op_s = ALU_PASS;
      alu_b_s  = imm_s;
      case (op_s)
         OP_ADDI: alu_op_s = ALU_ADD;
         OP_SUBI: alu_op_s = ALU_SUB;
         OP_AND:  begin alu_op_s = ALU_AND; alu_b_s = rs_val_s; end
         OP_OR:   begin alu_op_s = ALU_OR;  alu_b_s = rs_val_s; end
         OP_XOR:  begin alu_op_s = ALU_XOR; alu_b_s = rs_val_s; end
         OP_ADD:  begin alu_op_s = ALU_ADD; alu_b_s = rs_val_s; end
         OP_SUB:  begin alu_op_s = ALU_SUB; alu_b_s = rs_val_s; end
         default: begin alu_op_s = ALU_PASS; alu_b_s = imm_s; end
      endcase
   end

   pcpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (alu_op_s),
      .a      (rd_val_s),
      .b      (alu_b_s),
      .result (alu_res_s),
      .carry  (alu_carry_s),
      .zero   (alu_zero_s)
   );

   // Next-state, register-file write and flag update
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      regs_d    = regs_q;
      result_d  = result_q;
      flag_z_d  = flag_z_q;
      flag_c_d  = flag_c_q;
      illegal_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = S_EXEC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            case (op_s)
               OP_LDI, OP_ADDI, OP_SUBI, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: begin
                  regs_d[rd_s] = alu_res_s;
                  result_d     = alu_res_s;
                  flag_z_d     = alu_zero_s;
                  // LDI keeps carry; logic ops get 0 from the ALU, clearing it
                  flag_c_d     = (op_s == OP_LDI) ? flag_c_q : alu_carry_s;
                  state_d      = S_WB;
               end
               OP_LD, OP_ST: state_d = S_MEM;
               default: begin
                  illegal_s = 1'b1;
                  state_d   = S_IDLE;
               end
            endcase
         end
         S_MEM: begin
            if (mem_ack) begin
               if (op_s == OP_LD) begin
                  regs_d[rd_s] = mem_rdata;
                  result_d     = mem_rdata;
                  flag_z_d     = (mem_rdata == {DATA_W{1'b0}});
               end else begin
                  result_d = rd_val_s;
               end
               state_d = S_WB;
            end else begin
               state_d = S_MEM;
            end
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         instr_q  <= 16'h0000;
         result_q <= {DATA_W{1'b0}};
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         result_q <= result_d;
         flag_z_q <= flag_z_d;
         flag_c_q <= flag_c_d;
         regs_q   <= regs_d;
      end
   end

   assign instr_ready  = (state_q == S_IDLE);
   assign mem_req      = (state_q == S_MEM);
   assign mem_we       = (state_q == S_MEM) && (op_s == OP_ST);
   assign mem_addr     = instr_q[ADDR_W-1:0];
   assign mem_wdata    = rd_val_s;
   assign result       = result_q;
   assign result_valid = (state_q == S_WB);
   assign flag_z       = flag_z_q;
   assign flag_c       = flag_c_q;
   assign illegal      = illegal_s;

endmodule

// File: tb/tb_pcpu_core.sv
// Bench for pcpu_core: directed scenarios plus a random instruction stream,
// all compared against an arithmetic reference model of the instruction set.
module tb_pcpu_core;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready, mem_req, mem_we;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata, result;
   logic        mem_ack, result_valid, flag_z, flag_c, illegal;

   logic        b_instr_valid;
   logic [15:0] b_instr;
   logic        b_instr_ready, b_mem_req, b_mem_we;
   logic [7:0]  b_mem_addr;
   logic [15:0] b_mem_wdata, b_mem_rdata, b_result;
   logic        b_mem_ack, b_result_valid, b_flag_z, b_flag_c, b_illegal;

   int passes = 0;
   int fails  = 0;
   int total  = 0;

   logic [7:0] m_regs [16];
   logic [7:0] m_mem  [256];
   logic [7:0] m_res;
   logic       m_z, m_c;

   always #5 clk = ~clk;

   pcpu_core #(.DATA_W(8), .NREGS(16), .ADDR_W(8)) u_dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .result(result), .result_valid(result_valid),
      .flag_z(flag_z), .flag_c(flag_c), .illegal(illegal)
   );

   pcpu_core #(.DATA_W(16), .NREGS(4), .ADDR_W(8)) u_dut_w16 (
      .clk(clk), .reset(reset), .instr_valid(b_instr_valid), .instr(b_instr),
      .instr_ready(b_instr_ready), .mem_req(b_mem_req), .mem_we(b_mem_we),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
      .mem_ack(b_mem_ack), .result(b_result), .result_valid(b_result_valid),
      .flag_z(b_flag_z), .flag_c(b_flag_c), .illegal(b_illegal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_res = 8'h00;
      m_z   = 1'b0;
      m_c   = 1'b0;
   endtask

   // Issue one instruction at a negedge with ready high and follow it to completion
   task automatic run(input logic [15:0] ins, input int ack_dly);
      int         op, a, b, imm, s;
      logic [3:0] rd;
      logic [7:0] addr;
      logic       ill, memop;
      op   = int'(ins[15:12]);
      rd   = ins[11:8];
      a    = int'(m_regs[ins[11:8]]);
      b    = int'(m_regs[ins[7:4]]);
      imm  = int'(ins[7:0]);
      addr = ins[7:0];
      ill  = 1'b0;
      memop = 1'b0;
      check("ready_before", instr_ready, 1);
      instr_valid = 1'b1;
      instr       = ins;
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 16'($urandom);
      check("rv_in_exec", result_valid, 0);
      check("illegal_in_exec", illegal, (op >= 10) ? 1 : 0);
      check("ready_in_exec", instr_ready, 0);
      case (op)
         0: m_res = 8'(imm);
         1, 2: memop = 1'b1;
         3: begin s = a + imm; m_res = 8'(s); m_c = (s > 255); end
         4: begin s = a - imm; m_res = 8'(s); m_c = (a < imm); end
         5: begin m_res = 8'(a & b); m_c = 1'b0; end
         6: begin m_res = 8'(a | b); m_c = 1'b0; end
         7: begin m_res = 8'(a ^ b); m_c = 1'b0; end
         8: begin s = a + b; m_res = 8'(s); m_c = (s > 255); end
         9: begin s = a - b; m_res = 8'(s); m_c = (a < b); end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         @(negedge clk);
         check("ready_after_illegal", instr_ready, 1);
         check("illegal_one_cycle", illegal, 0);
         check("rv_after_illegal", result_valid, 0);
      end else if (!memop) begin
         m_z = (m_res == 8'h00);
         m_regs[rd] = m_res;
         @(negedge clk);
         check("rv_alu", result_valid, 1);
         check("result_alu", result, m_res);
         check("z_alu", flag_z, m_z);
         check("c_alu", flag_c, m_c);
         @(negedge clk);
         check("rv_drop", result_valid, 0);
      end else begin
         @(negedge clk);
         for (int k = 0; k < ack_dly; k++) begin
            check("mem_req", mem_req, 1);
            check("mem_we", mem_we, (op == 1) ? 1 : 0);
            check("mem_addr", mem_addr, addr);
            if (op == 1) check("mem_wdata", mem_wdata, a);
            if (k == ack_dly - 1) begin
               mem_ack   = 1'b1;
               mem_rdata = m_mem[addr];
            end
            @(negedge clk);
         end
         mem_ack   = 1'b0;
         mem_rdata = 8'($urandom);
         if (op == 1) begin
            m_mem[addr] = 8'(a);
            m_res = 8'(a);
         end else begin
            m_res = m_mem[addr];
            m_z = (m_res == 8'h00);
            m_regs[rd] = m_res;
         end
         check("mem_req_drop", mem_req, 0);
         check("rv_mem", result_valid, 1);
         check("result_mem", result, m_res);
         check("z_mem", flag_z, m_z);
         check("c_mem", flag_c, m_c);
         @(negedge clk);
      end
      check("flags_z_final", flag_z, m_z);
      check("flags_c_final", flag_c, m_c);
   endtask

   task automatic run_w16(input logic [15:0] ins, input logic [15:0] exp, input logic exp_c);
      b_instr_valid = 1'b1;
      b_instr       = ins;
      @(negedge clk);
      b_instr_valid = 1'b0;
      @(negedge clk);
      check("w16_rv", b_result_valid, 1);
      check("w16_result", b_result, exp);
      check("w16_c", b_flag_c, exp_c);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      instr_valid = 1'b0;
      instr = 16'h0000;
      mem_rdata = 8'h00;
      mem_ack = 1'b0;
      b_instr_valid = 1'b0;
      b_instr = 16'h0000;
      b_mem_rdata = 16'h0000;
      b_mem_ack = 1'b0;
      for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
      model_reset();
      @(negedge clk);
      check("rst_ready", instr_ready, 1);
      check("rst_mem_req", mem_req, 0);
      check("rst_rv", result_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", {illegal, flag_z, flag_c}, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Directed scenarios
      run(16'h0105, 1);
      run(16'h31FB, 1);
      check("addi_wrap_zero", {result, flag_z, flag_c}, {8'h00, 1'b1, 1'b1});
      run(16'h0203, 1);
      run(16'h4204, 1);
      check("subi_borrow", {result, flag_z, flag_c}, {8'hFF, 1'b0, 1'b1});
      run(16'h03A5, 1);
      run(16'h1310, 3);
      m_mem[8'h10] = 8'hA5;
      run(16'h2410, 2);
      run(16'h1420, 1);
      check("ld_r4_value", result, 8'hA5);
      run(16'hC000, 1);
      run(16'h7550, 1);
      check("xor_self", result, 8'h00);

      // ack while idle must be ignored
      mem_ack = 1'b1;
      mem_rdata = 8'h5C;
      @(negedge clk);
      mem_ack = 1'b0;
      check("idle_ack_ready", instr_ready, 1);
      check("idle_ack_rv", result_valid, 0);
      check("idle_ack_result", result, m_res);

      // Reset in the middle of a store
      instr_valid = 1'b1;
      instr = 16'h1330;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_mem_req", mem_req, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_mem_req", mem_req, 0);
      check("rst_mid_ready", instr_ready, 1);
      check("rst_mid_state", {result, flag_z, flag_c}, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("late_ack_rv", result_valid, 0);
      check("late_ack_ready", instr_ready, 1);
      run(16'h015A, 1);
      run(16'h1330, 1);
      check("reg_cleared_by_reset", result, 8'h00);

      // Random stream
      for (int n = 0; n < 60; n++) begin
         int         r;
         logic [3:0] op;
         logic [15:0] ins;
         r   = int'($urandom_range(0, 19));
         op  = (r < 18) ? 4'(r % 10) : 4'(10 + $urandom_range(0, 5));
         ins = {op, 4'($urandom), 8'($urandom)};
         if (op == 4'd1 || op == 4'd2) ins[7:0] = 8'h40 + 8'($urandom_range(0, 7));
         run(ins, int'($urandom_range(1, 4)));
         if ($urandom_range(0, 3) == 0) begin
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            check("rand_idle_ack", {instr_ready, result_valid}, 2'b10);
         end
      end

      // Wider datapath, four registers: r5 aliases r1
      run_w16(16'h05FF, 16'h00FF, 1'b0);
      run_w16(16'h8110, 16'h01FE, 1'b0);
      run_w16(16'h8550, 16'h03FC, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
